// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_wide_sequencer
// Function : Runs a 32-bit ADD/SUB/AND/XOR as two 16-bit ALU passes, low
//            half then high half, carry chained through the ALU's C flag.
// Revision : 1.0
// ============================================================================
module alu_wide_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [3:0]  ResultFlags,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [15:0] AluOut,
    input  logic [3:0]  AluFlags
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;
    localparam logic [1:0] c_OP_XOR = 2'b11;

    localparam logic [4:0] c_FS_PASS = 5'b10000;
    localparam logic [4:0] c_FS_ADD  = 5'b10100;
    localparam logic [4:0] c_FS_ADC  = 5'b10101;
    localparam logic [4:0] c_FS_SUB  = 5'b10110;
    localparam logic [4:0] c_FS_AND  = 5'b10111;
    localparam logic [4:0] c_FS_XOR  = 5'b11001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic        r_done;
    logic [31:0] r_result;
    logic [3:0]  r_flags;
    logic [15:0] w_hi_b;
    logic        w_arith;

    assign w_arith = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
    // High half of SUB is A + ~B + C, so B is inverted before it reaches the ALU.
    assign w_hi_b  = (r_op == c_OP_SUB) ? ~r_b[31:16] : r_b[31:16];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= c_OP_ADD;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_WB);
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_a  <= OpA;
                        r_b  <= OpB;
                        r_op <= Op;
                    end
                end
                S_LO: r_result[15:0]  <= AluOut;
                S_HI: r_result[31:16] <= AluOut;
                S_WB: begin
                    // ALU Z only covers the high half, so Z is rebuilt over 32 bits.
                    r_flags[3] <= (r_result == 32'd0);
                    r_flags[2] <= w_arith ? AluFlags[2] : 1'b0;
                    r_flags[1] <= r_result[31];
                    r_flags[0] <= w_arith ? AluFlags[0] : 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        AluA      = 16'd0;
        AluB      = 16'd0;
        AluFunSel = c_FS_PASS;
        AluWF     = 1'b0;
        case (r_state)
            S_IDLE: if (Start) w_next = S_LO;
            S_LO: begin
                w_next = S_HI;
                AluA   = r_a[15:0];
                AluB   = r_b[15:0];
                AluWF  = 1'b1;
                case (r_op)
                    c_OP_ADD: AluFunSel = c_FS_ADD;
                    c_OP_SUB: AluFunSel = c_FS_SUB;
                    c_OP_AND: AluFunSel = c_FS_AND;
                    default:  AluFunSel = c_FS_XOR;
                endcase
            end
            S_HI: begin
                w_next = S_WB;
                AluA   = r_a[31:16];
                AluB   = w_hi_b;
                AluWF  = 1'b1;
                case (r_op)
                    c_OP_ADD, c_OP_SUB: AluFunSel = c_FS_ADC;
                    c_OP_AND:           AluFunSel = c_FS_AND;
                    default:            AluFunSel = c_FS_XOR;
                endcase
            end
            S_WB: begin
                w_next = S_IDLE;
                AluA   = r_a[31:16];
                AluB   = w_hi_b;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign Busy        = (r_state != S_IDLE);
    assign Done        = r_done;
    assign Result      = r_result;
    assign ResultFlags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wide_sequencer
// Function : Bench for alu_wide_sequencer with a 16-bit ALU model attached;
//            results are compared with plain 32-bit arithmetic.
// Revision : 1.0
// ============================================================================
module tb_alu_wide_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op    = 2'b00;
    logic [31:0] OpA   = '0;
    logic [31:0] OpB   = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [3:0]  ResultFlags;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [15:0] AluOut;
    logic [3:0]  AluFlags;

    int checks = 0;
    int errors = 0;

    alu_wide_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
        .OpA(OpA), .OpB(OpB), .Busy(Busy), .Done(Done),
        .Result(Result), .ResultFlags(ResultFlags),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags)
    );

    always #5 Clock = ~Clock;

    // 16-bit ALU model: combinational output, flags {Z,C,N,V} registered when WF=1.
    logic [3:0]  alu_flag_reg;
    logic [3:0]  alu_flag_nxt;
    logic [16:0] alu_sum;
    assign AluFlags = alu_flag_reg;

    always_comb begin
        AluOut       = AluA;
        alu_sum      = 17'd0;
        alu_flag_nxt = alu_flag_reg;
        case (AluFunSel)
            5'b10100: begin
                alu_sum = {1'b0, AluA} + {1'b0, AluB};
                alu_flag_nxt[2] = alu_sum[16];
                alu_flag_nxt[0] = (AluA[15] == AluB[15]) && (alu_sum[15] != AluA[15]);
                AluOut = alu_sum[15:0];
            end
            5'b10101: begin
                alu_sum = {1'b0, AluA} + {1'b0, AluB} + {16'd0, alu_flag_reg[2]};
                alu_flag_nxt[2] = alu_sum[16];
                alu_flag_nxt[0] = (AluA[15] == AluB[15]) && (alu_sum[15] != AluA[15]);
                AluOut = alu_sum[15:0];
            end
            5'b10110: begin
                alu_sum = {1'b0, AluA} + {1'b0, ~AluB} + 17'd1;
                alu_flag_nxt[2] = alu_sum[16];
                alu_flag_nxt[0] = (AluA[15] != AluB[15]) && (alu_sum[15] != AluA[15]);
                AluOut = alu_sum[15:0];
            end
            5'b10111: AluOut = AluA & AluB;
            5'b11001: AluOut = AluA ^ AluB;
            default:  AluOut = AluA;
        endcase
        alu_flag_nxt[3] = (AluOut == 16'd0);
        alu_flag_nxt[1] = AluOut[15];
    end

    always @(posedge Clock) if (AluWF) alu_flag_reg <= alu_flag_nxt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole 32-bit operation in one step.
    task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f);
        logic [32:0] s;
        logic c, v;
        c = 1'b0; v = 1'b0; s = '0;
        case (op)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            2'b01: begin
                r = a - b; c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        f = {(r == 32'd0), c, r[31], v};
    endtask

    // Waits up to a bound for Done; returns number of edges after the accepting one.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge Clock); #1;
            if (Done) begin edges = i; break; end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic [3:0]  ef;
        int n;
        ref_op(op, a, b, er, ef);
        Op = op; OpA = a; OpB = b; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done(n);
        check({tag, " latency"}, n, 3);
        check({tag, " result"}, Result, er);
        check({tag, " flags"}, {28'd0, ResultFlags}, {28'd0, ef});
        check({tag, " busy_in_done"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int n, dones;
        logic [31:0] er;
        logic [3:0]  ef;

        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("rst busy", {31'd0, Busy}, 0);
        check("rst done", {31'd0, Done}, 0);
        check("rst result", Result, 0);
        check("rst flags", {28'd0, ResultFlags}, 0);
        check("rst alu", {AluA, AluB}, 0);
        check("rst funsel", {27'd0, AluFunSel}, 32'h10);
        check("rst wf", {31'd0, AluWF}, 0);

        run_op("add_carry16", 2'b00, 32'h0000FFFF, 32'h00000001);
        check("add_carry16 exact", {Result, 28'd0, ResultFlags}, 64'h00010000_00000000);
        @(posedge Clock); #1;
        check("done one cycle", {31'd0, Done}, 0);
        run_op("sub_borrow", 2'b01, 32'h00000000, 32'h00000001);
        check("sub_borrow exact", {28'd0, ResultFlags}, 32'b0010);
        run_op("sub_hi", 2'b01, 32'h00010000, 32'h00000001);
        check("sub_hi exact", {Result, 28'd0, ResultFlags}, 64'h0000FFFF_00000004);
        run_op("add_ovf", 2'b00, 32'h7FFFFFFF, 32'h00000001);
        check("add_ovf exact", {28'd0, ResultFlags}, 32'b0011);
        run_op("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h00000001);
        check("add_wrap exact", {28'd0, ResultFlags}, 32'b1100);
        run_op("xor_zero", 2'b11, 32'h12345678, 32'h12345678);
        check("xor_zero exact", {28'd0, ResultFlags}, 32'b1000);
        run_op("and_neg", 2'b10, 32'hFFFF0000, 32'h8000FFFF);
        check("and_neg exact", {Result, 28'd0, ResultFlags}, 64'h80000000_00000002);

        // Start pulsed while busy is ignored.
        Op = 2'b00; OpA = 32'd5; OpB = 32'd7; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            OpA = 32'hDEAD0000; Start = 1'b1;
            @(posedge Clock); #1;
            Start = 1'b0;
            if (Done) dones++;
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
        check("ignored start dones", dones, 1);
        check("ignored start result", Result, 32'd12);

        // Start held through the Done cycle yields back-to-back operations.
        Op = 2'b00; OpA = 32'h11110000; OpB = 32'h00002222; Start = 1'b1;
        @(posedge Clock); #1;
        wait_done(n);
        check("b2b first latency", n, 3);
        check("b2b first result", Result, 32'h11112222);
        Op = 2'b01; OpA = 32'h00000010; OpB = 32'h00000020;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("b2b accepted", {31'd0, Busy}, 1);
        wait_done(n);
        ref_op(2'b01, 32'h10, 32'h20, er, ef);
        check("b2b second latency", n, 3);
        check("b2b second result", Result, er);
        check("b2b second flags", {28'd0, ResultFlags}, {28'd0, ef});

        // Reset during HI aborts with no Done.
        Op = 2'b00; OpA = 32'h12345678; OpB = 32'h11111111; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("abort busy", {31'd0, Busy}, 0);
        check("abort done", {31'd0, Done}, 0);
        check("abort result", Result, 0);
        check("abort flags", {28'd0, ResultFlags}, 0);
        check("abort funsel", {27'd0, AluFunSel, AluWF}, 32'h20);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            if (Done) dones++;
        end
        check("abort no done", dones, 0);
        run_op("post_abort", 2'b00, 32'h0001FFFF, 32'h00000001);
        check("post_abort exact", {Result, 28'd0, ResultFlags}, 64'h00020000_00000000);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 8 == 0) ? ra : $urandom;
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout: simulation exceeded time limit");
    end

endmodule
`default_nettype wire

// File: doc/alu_wide_sequencer.md
# alu_wide_sequencer

Upstream control stage for the 16-bit ALU: accepts a 32-bit ADD/SUB/AND/XOR request and runs it as two back-to-back 16-bit ALU passes, low half then high half. Carry is chained through the ALU's own carry flag using its add-with-carry function. The block drives the ALU's A, B, FunSel and WF inputs, captures ALUOut, and returns a 32-bit result with 32-bit-correct flags. While Busy is high it is the sole driver of the ALU.

## Interface
Parameters: none; widths fixed at 32-bit request and 16-bit ALU.

- Clock  in  1  rising-edge clock shared with the ALU
- Reset  in  1  synchronous, active-high
- Start  in  1  request strobe; accepted only when Busy=0
- Op  in  2  00 ADD, 01 SUB (OpA−OpB), 10 AND, 11 XOR
- OpA  in  32  operand A, sampled on the accepting edge
- OpB  in  32  operand B, sampled on the accepting edge
- Busy  out  1  high while the operation is in progress
- Done  out  1  one-cycle pulse; Result and ResultFlags are valid from this cycle on
- Result  out  32  result, held until the next accepted Start or Reset
- ResultFlags  out  4  {Z,C,N,V}, same bit order as the ALU FlagsOut, held with Result
- AluA  out  16  to ALU A
- AluB  out  16  to ALU B
- AluFunSel  out  5  to ALU FunSel
- AluWF  out  1  to ALU WF
- AluOut  in  16  from ALU ALUOut (combinational)
- AluFlags  in  4  from ALU FlagsOut (registered on Clock inside the ALU)

## Operation
- States: IDLE, LO, HI, WB.
  - IDLE→LO on Start.
  - LO→HI, HI→WB and WB→IDLE unconditionally.
- Accepting edge (IDLE with Start=1): latch OpA, OpB and Op.
  - Start is ignored in LO, HI and WB; no queueing.
- Outputs by state:
  - IDLE: AluA=0, AluB=0, AluFunSel=5'b10000, AluWF=0.
  - LO: AluA=A[15:0], AluWF=1.
    - ADD: AluB=B[15:0], FunSel 5'b10100.
    - SUB: AluB=B[15:0], FunSel 5'b10110.
    - AND: AluB=B[15:0], FunSel 5'b10111.
    - XOR: AluB=B[15:0], FunSel 5'b11001.
  - HI: AluA=A[31:16], AluWF=1.
    - ADD: AluB=B[31:16], FunSel 5'b10101.
    - SUB: AluB=~B[31:16], FunSel 5'b10101, computing A+~B+C.
    - AND: AluB=B[31:16], FunSel 5'b10111.
    - XOR: AluB=B[31:16], FunSel 5'b11001.
  - WB: AluWF=0; FunSel 5'b10000; AluA and AluB hold their HI values.
- Result capture:
  - End of LO: Result[15:0]←AluOut. The ALU latches the low-pass carry on the same edge.
  - End of HI: Result[31:16]←AluOut.
- End of WB, ResultFlags loaded as:
  - Z = (Result==0) over all 32 bits; the ALU's Z covers only the high half and is not used.
  - N = Result[31].
  - ADD/SUB: C = AluFlags[2], V = AluFlags[0]. These are the high-pass flags.
  - AND/XOR: C = 0, V = 0.
- SUB carry convention: C=1 means no borrow (A ≥ B unsigned).
- The ALU flag register is never reset. This is safe because the low pass of ADD/SUB always rewrites C before the high pass reads it.
- Reset, synchronous, takes priority over everything including Start:
  - state→IDLE; Busy=0, Done=0, Result=0, ResultFlags=0.
  - ALU drive outputs go to their IDLE values.
  - An aborted operation produces no Done.

## Timing
- Edge 0 accepts Start. Cycle 1=LO, cycle 2=HI, cycle 3=WB. Done=1 in cycle 4, which is the first IDLE cycle.
- Latency Start→Done = 4 cycles; throughput one operation per 4 cycles.
- Busy=1 in cycles 1–3; Busy=0 in the Done cycle.
- Start asserted in the Done cycle is accepted at that edge, giving back-to-back operation.
- Done is registered and lasts exactly one cycle.
- Result[15:0] updates at the end of cycle 1 and Result[31:16] at the end of cycle 2. Result is not guaranteed stable before Done.
- Reset values: Busy 0, Done 0, Result 0, ResultFlags 0, AluA 0, AluB 0, AluFunSel 5'b10000, AluWF 0.

## Test plan
- ADD 0x0000FFFF + 0x00000001 → Result 0x00010000, ZCNV=0000, Done in cycle 4.
- SUB 0x00000000 − 0x00000001 → 0xFFFFFFFF, ZCNV=0010 (C=0, borrow). SUB 0x00010000 − 0x00000001 → 0x0000FFFF, ZCNV=0100.
- ADD 0x7FFFFFFF + 0x00000001 → 0x80000000, ZCNV=0011. ADD 0xFFFFFFFF + 0x00000001 → 0x00000000, ZCNV=1100.
- XOR 0x12345678 ^ 0x12345678 → 0, ZCNV=1000. AND 0xFFFF0000 & 0x8000FFFF → 0x80000000, ZCNV=0010.
- Start pulsed in cycles 1–3 → ignored, exactly one Done. Start held through the Done cycle → second operation accepted, second Done 4 cycles later.
- Reset in HI → next cycle Busy=0, Result=0, ResultFlags=0, no Done. A following ADD 0x0001FFFF + 0x00000001 → 0x00020000, ZCNV=0000.
